priority_encoder_16x4: RTL and testbench

PRIORITY_ENCODER_16X4 -- requirements
Module: priority_encoder_16x4

---
 rtl/priority_encoder_16x4.sv | 122 ++++++++++++
 tb/tb_priority_encoder_16x4.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_16x4.sv
// Pending-request priority encoder: 16 sticky request bits, one code presented
// at a time over valid/ready. Define PRIORITY_ENCODER_RR_EN for round-robin selection.
module priority_encoder_16x4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] in,
  output logic [3:0]  out,
  output logic        valid,
  input  logic        ready,
  output logic [15:0] pending
);

  // Handshake: a code transfers on a rising edge where valid=1 and ready=1;
  // valid and out never change while valid=1 and ready=0, and ready is
  // don't-care while valid=0.

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_out;
  logic [3:0]  w_out_next;
  logic [15:0] r_pending;
  logic [15:0] w_next_pending;
  logic [15:0] w_clear;
  logic        w_accept;
  logic [3:0]  w_sel;

`ifdef PRIORITY_ENCODER_RR_EN
  logic [3:0] r_ptr;
  logic [3:0] w_ptr_next;

  function automatic logic [3:0] pick_rr(input logic [15:0] req, input logic [3:0] start);
    logic       found;
    logic [3:0] idx;
    pick_rr = '0;
    found   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = start + 4'(k);
      if (!found && req[idx]) begin
        pick_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction
`else
  function automatic logic [3:0] pick_fixed(input logic [15:0] req);
    pick_fixed = '0;
    for (int i = 0; i < 16; i++) begin
      if (req[i]) pick_fixed = 4'(i);
    end
  endfunction
`endif

  always_comb begin
    w_accept       = (r_state == S_PRESENT) && ready;
    w_clear        = w_accept ? (16'h0001 << r_out) : 16'h0000;
    // New requests OR in after the clear, so a same-cycle set wins.
    w_next_pending = (r_pending & ~w_clear) | (en ? in : 16'h0000);
`ifdef PRIORITY_ENCODER_RR_EN
    w_ptr_next     = w_accept ? (r_out + 4'd1) : r_ptr;
    w_sel          = pick_rr(w_next_pending, w_ptr_next);
`else
    w_sel          = pick_fixed(w_next_pending);
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_out;
    case (r_state)
      S_IDLE: begin
        if (|w_next_pending) begin
          w_state_next = S_PRESENT;
          w_out_next   = w_sel;
        end
      end
      S_PRESENT: begin
        if (ready) begin
          if (|w_next_pending) begin
            w_out_next = w_sel;
          end else begin
            w_state_next = S_IDLE;
            w_out_next   = 4'd0;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_out_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_out     <= 4'd0;
      r_pending <= 16'h0000;
    end else begin
      r_state   <= w_state_next;
      r_out     <= w_out_next;
      r_pending <= w_next_pending;
    end
  end

`ifdef PRIORITY_ENCODER_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= 4'd0;
    else     r_ptr <= w_ptr_next;
  end
`endif

  assign out     = r_out;
  assign valid   = (r_state == S_PRESENT);
  assign pending = r_pending;

endmodule

// File: tb/tb_priority_encoder_16x4.sv
// Directed bench for priority_encoder_16x4; round-robin vectors run only when
// PRIORITY_ENCODER_RR_EN is defined.
module tb_priority_encoder_16x4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] in;
  logic [3:0]  out;
  logic        valid;
  logic        ready;
  logic [15:0] pending;

  int n_checks = 0;
  int n_pass   = 0;

  priority_encoder_16x4 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (in),
    .out     (out),
    .valid   (valid),
    .ready   (ready),
    .pending (pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [15:0] d, input logic r);
    en    = e;
    in    = d;
    ready = r;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [3:0] o, input logic [15:0] p);
    chk({tag, "_valid"},   16'(valid),   16'(v));
    chk({tag, "_out"},     16'(out),     16'(o));
    chk({tag, "_pending"}, pending,      p);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    #3;
    chk_all("reset", 1'b0, 4'd0, 16'h0000);
    step();
    step();
    #2 rst = 1'b0;
    step();
    chk_all("post_reset", 1'b0, 4'd0, 16'h0000);

    // ready while idle is ignored; en=0 gates in
    drive(1'b0, 16'hFFFF, 1'b1);
    step();
    chk_all("en_gate", 1'b0, 4'd0, 16'h0000);

`ifndef PRIORITY_ENCODER_RR_EN
    // single request, held then accepted
    drive(1'b1, 16'h0020, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    chk_all("single", 1'b1, 4'd5, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("single_hold", 1'b1, 4'd5, 16'h0020);
    end
    ready = 1'b1;
    step();
    chk_all("single_acc", 1'b0, 4'd0, 16'h0000);

    // multi-hot, back-to-back drain
    drive(1'b1, 16'h8101, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b1);
    chk_all("multi_15", 1'b1, 4'd15, 16'h8101);
    step();
    chk_all("multi_8", 1'b1, 4'd8, 16'h0101);
    step();
    chk_all("multi_0", 1'b1, 4'd0, 16'h0001);
    step();
    chk_all("multi_end", 1'b0, 4'd0, 16'h0000);

    // hold stability against a higher-priority arrival
    drive(1'b1, 16'h0008, 1'b0);
    step();
    chk_all("hold_3", 1'b1, 4'd3, 16'h0008);
    drive(1'b1, 16'h8000, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0);
    chk_all("hold_stay", 1'b1, 4'd3, 16'h8008);
    step();
    chk_all("hold_stay2", 1'b1, 4'd3, 16'h8008);
    ready = 1'b1;
    step();
    chk_all("hold_next", 1'b1, 4'd15, 16'h8000);
    step();
    chk_all("hold_end", 1'b0, 4'd0, 16'h0000);

    // set/clear collision: set wins
    drive(1'b1, 16'h0080, 1'b0);
    step();
    chk_all("coll_pre", 1'b1, 4'd7, 16'h0080);
    drive(1'b1, 16'h0080, 1'b1);
    step();
    chk_all("coll", 1'b1, 4'd7, 16'h0080);
    drive(1'b0, 16'h0000, 1'b1);
    step();
    chk_all("coll_end", 1'b0, 4'd0, 16'h0000);
`else
    // full sweep starting from pointer 0
    drive(1'b1, 16'hFFFF, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("rr_sweep_out", 16'(out), 16'(i));
      chk("rr_sweep_valid", 16'(valid), 16'h0001);
      step();
    end
    chk_all("rr_sweep_end", 1'b0, 4'd0, 16'h0000);

    // pointer wrapped to 0
    drive(1'b1, 16'h0003, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b1);
    chk_all("rr_low_0", 1'b1, 4'd0, 16'h0003);
    step();
    chk_all("rr_low_1", 1'b1, 4'd1, 16'h0002);
    step();
    chk_all("rr_low_end", 1'b0, 4'd0, 16'h0000);

    // pointer now 2: index 2 beats 15
    drive(1'b1, 16'h8004, 1'b1);
    step();
    drive(1'b0, 16'h0000, 1'b1);
    chk_all("rr_ptr_2", 1'b1, 4'd2, 16'h8004);
    step();
    chk_all("rr_ptr_15", 1'b1, 4'd15, 16'h8000);
    step();
    chk_all("rr_ptr_end", 1'b0, 4'd0, 16'h0000);

    drive(1'b0, 16'hFFFF, 1'b1);
    step();
    chk_all("rr_en_gate", 1'b0, 4'd0, 16'h0000);
`endif

    // asynchronous reset while presenting
    drive(1'b1, 16'h0404, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b0);
`ifndef PRIORITY_ENCODER_RR_EN
    chk_all("rst_pre", 1'b1, 4'd10, 16'h0404);
`else
    chk_all("rst_pre", 1'b1, 4'd2, 16'h0404);
`endif
    #2 rst = 1'b1;
    #1;
    chk_all("rst_async", 1'b0, 4'd0, 16'h0000);
    drive(1'b1, 16'hFFFF, 1'b1);
    step();
    chk_all("rst_ignore_in", 1'b0, 4'd0, 16'h0000);
    #2;
    drive(1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    step();
    step();
    chk_all("rst_release", 1'b0, 4'd0, 16'h0000);

    // first capture after release
    drive(1'b1, 16'h0002, 1'b0);
    step();
    drive(1'b0, 16'h0000, 1'b1);
    chk_all("first_cap", 1'b1, 4'd1, 16'h0002);
    step();
    chk_all("first_cap_acc", 1'b0, 4'd0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
